// File: rtl/clarvi_pio_pkg.sv
// Shared definitions for the clarvi_soc parallel I/O blocks (button and LED PIOs).
// Register map word addresses and edge-detect selections.
package clarvi_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Edge vector from the current and previous debounced levels.
  function automatic logic [31:0] pio_edges(input int edge_type,
                                            input logic [31:0] stable,
                                            input logic [31:0] prev);
    case (edge_type)
      EDGE_RISE: pio_edges = stable & ~prev;
      EDGE_FALL: pio_edges = ~stable & prev;
      default:   pio_edges = stable ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer: a new level is accepted only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current stable level.
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_sync,
  output logic q_stable
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign q_stable = d_sync;
    end else begin : g_filter
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          stable_q;

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt      <= '0;
          stable_q <= 1'b0;
        end else if (d_sync == stable_q) begin
          cnt <= '0;
        end else if (cnt >= LAST) begin
          stable_q <= d_sync;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign q_stable = stable_q;
    end
  endgenerate

endmodule

// File: rtl/clarvi_soc_buttons_pio.sv
// Avalon-MM input PIO for push-buttons/switches: synchronise, debounce, capture
// edges into a write-1-to-clear register and raise a maskable level IRQ.
module clarvi_soc_buttons_pio
  import clarvi_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;

  // NOTE: every register, including the synchroniser, is asynchronously reset
  // so no stale level or pending interrupt survives reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .d_sync  (sync2[i]),
      .q_stable(stable[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= stable;
  end

  assign wr_en = chipselect & ~write_n;
  assign edges = WIDTH'(pio_edges(EDGE_TYPE, 32'(stable), 32'(prev)));

  // NOTE: combinational outputs get a default before any conditional so no latch is inferred.
  always_comb begin
    clr = '0;
    if (wr_en && address == PIO_ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
  end

  // A new edge overrides a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= (edgecap & ~clr) | edges;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   irqmask <= '0;
    else if (wr_en && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux = 32'(stable);
      PIO_ADDR_IRQMASK: rd_mux = 32'(irqmask);
      PIO_ADDR_EDGECAP: rd_mux = 32'(edgecap);
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecap & irqmask);

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_clarvi_soc_buttons_pio.sv
// Bench for clarvi_soc_buttons_pio: directed scenarios plus random traffic,
// compared every cycle against a window-based behavioural model.
module tb_clarvi_soc_buttons_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [W-1:0]  in_port    = 4'hF;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  clarvi_soc_buttons_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bit's level is accepted once the last D synchronised
  // samples all disagree with the currently accepted level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_prev = '0;
  logic [W-1:0] m_cap = '0, m_mask = '0;
  logic [31:0]  m_rd = '0;
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_ns, m_fall, m_clr;
  logic [31:0]  m_rd_next;
  bit           m_all;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      m_cap = '0; m_mask = '0; m_rd = '0;
      m_hist.delete();
    end else begin
      case (address)
        2'd0:    m_rd_next = {28'd0, m_stable};
        2'd2:    m_rd_next = {28'd0, m_mask};
        2'd3:    m_rd_next = {28'd0, m_cap};
        default: m_rd_next = 32'd0;
      endcase
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      m_ns = m_stable;
      if (m_hist.size() == D) begin
        for (int i = 0; i < W; i++) begin
          m_all = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) m_ns[i] = ~m_stable[i];
        end
      end
      m_fall = m_prev & ~m_stable;
      m_clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap  = (m_cap & ~m_clr) | m_fall;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_prev   = m_stable;
      m_stable = m_ns;
      m_s2     = m_s1;
      m_s1     = in_port;
      m_rd     = m_rd_next;
    end
  end

  // Compare process: outputs are checked on every falling edge.
  always @(negedge clk) begin
    check("readdata_vs_model", readdata, m_rd);
    check("irq_vs_model", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic read_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    tick();
    check(name, readdata, exp);
  endtask

  initial begin
    // Reset with all inputs high: the rising level shows up after sync + debounce.
    tick(3);
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    tick(6);
    check("data_before_accept", readdata, 32'h0);
    tick();
    check("data_after_accept", readdata, 32'hF);
    read_expect(2'd3, 32'h0, "cap_after_reset_rise");
    check("irq_after_reset", {31'd0, irq}, 32'd0);

    // Falling edge on bit 0, masked, then unmasked.
    address = 2'd0;
    in_port = 4'hE;
    tick(6);
    check("data_fall_pending", readdata, 32'hF);
    tick();
    check("data_fall_accepted", readdata, 32'hE);
    read_expect(2'd3, 32'h1, "cap_bit0");
    check("irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h1);
    check("irq_unmasked", {31'd0, irq}, 32'd1);

    // Bounce on bit 1: runs of 2 never reach the debounce threshold.
    address = 2'd0;
    for (int t = 0; t < 10; t++) begin
      in_port[1] = ~in_port[1];
      repeat (2) begin
        tick();
        check("bounce_stable1", {31'd0, readdata[1]}, 32'd1);
      end
    end
    tick(8);
    read_expect(2'd3, 32'h1, "bounce_no_cap");

    // Write-1-to-clear.
    in_port = 4'hC;
    tick(8);
    read_expect(2'd3, 32'h3, "cap_two_bits");
    bus_write(2'd3, 32'h1);
    read_expect(2'd3, 32'h2, "w1c_bit0");
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Falling edge on bit 2 lands in the same cycle as its clear write.
    in_port = 4'h8;
    tick(6);
    bus_write(2'd3, 32'h4);
    read_expect(2'd3, 32'h6, "simul_set_wins");

    // Reserved address and over-width writes.
    bus_write(2'd1, 32'hFFFF_FFFF);
    read_expect(2'd1, 32'h0, "rsvd_read");
    read_expect(2'd2, 32'h1, "mask_kept");
    read_expect(2'd3, 32'h6, "cap_kept");
    bus_write(2'd2, 32'hFFFF_FFF0);
    read_expect(2'd2, 32'h0, "mask_upper_dropped");

    // All bits captured and unmasked, then asynchronous reset mid-cycle.
    in_port = 4'hF;
    tick(8);
    in_port = 4'h0;
    tick(8);
    read_expect(2'd3, 32'hF, "cap_all");
    bus_write(2'd2, 32'hF);
    check("irq_all", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    check("readdata_async_reset", readdata, 32'd0);
    tick(2);
    reset_n = 1'b1;
    read_expect(2'd2, 32'h0, "mask_after_reset");
    read_expect(2'd3, 32'h0, "cap_after_reset");

    // Random traffic: mostly held inputs with occasional glitch bursts.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) in_port = W'($urandom);
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = ($urandom_range(0, 1) == 1);
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
